// File: rtl/cache_pkg.sv
// Shared types and constants for the cache line refill controller.
package cache_pkg;

  // Refill sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  // Line geometry: 128-byte lines filled as 32 x 32-bit beats.
  localparam int LINE_BYTES = 128;
  localparam int WORDS      = LINE_BYTES / 4;
  localparam int OFFSET_W   = 7;

  // AXI4 encodings used by the refill burst.
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // Any response other than OKAY counts as a refill error.
  function automatic logic resp_is_error(input logic [1:0] resp);
    return (resp != RESP_OKAY);
  endfunction

endpackage

// File: rtl/refill_beat_ctr.sv
// Beat counter and fill-address generator for one cache line refill.
// beat_addr is the word address of the beat the counter currently points at;
// is_last flags the final beat of the line.
module refill_beat_ctr #(
  parameter int ADDR_W = 32,
  parameter int WORDS  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              inc,
  input  logic [ADDR_W-1:0] base,
  output logic [ADDR_W-1:0] beat_addr,
  output logic              is_last
);

  localparam int CNT_W = $clog2(WORDS);

  logic [CNT_W-1:0] cnt;

  assign is_last   = (cnt == CNT_W'(WORDS - 1));
  assign beat_addr = base + {{(ADDR_W - CNT_W - 2){1'b0}}, cnt, 2'b00};

  // Beat counter: cleared at launch, advances per accepted beat, saturates at the last word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc && !is_last) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Cache line refill controller: converts a cache miss into one AXI4 INCR
// read burst and replays the returned beats on the cache word-fill port,
// never strobing the fill port on two consecutive cycles.
module cache_refill_ctrl
  import cache_pkg::state_t, cache_pkg::IDLE, cache_pkg::ADDR,
         cache_pkg::DATA, cache_pkg::DONE, cache_pkg::BURST_INCR,
         cache_pkg::SIZE_4B, cache_pkg::resp_is_error;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_BYTES = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              miss,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_data_valid,
  output logic              mem_last,
  output logic [3:0]        mem_wstb,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic              err
);

  localparam int WORDS = LINE_BYTES / 4;
  localparam int OFF_W = $clog2(LINE_BYTES);

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] held_addr;
  logic              end_pending;

  logic [ADDR_W-1:0] line_base;
  logic [ADDR_W-1:0] beat_addr;
  logic              beat_is_last;
  logic              r_hs;
  logic              ar_hs;
  logic              beat_err;
  logic              launch;

  assign line_base = {cpu_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign ar_hs     = m_arvalid && m_arready;
  assign r_hs      = m_rvalid && m_rready;
  assign launch    = (state == IDLE) && miss;

  // Bad response, or rlast disagreeing with the line length, is a refill error.
  assign beat_err  = r_hs && (resp_is_error(m_rresp) || (m_rlast != beat_is_last));

  // AR channel fields are fixed for the whole line; only the address varies.
  assign m_araddr  = base;
  assign m_arlen   = 8'(WORDS - 1);
  assign m_arsize  = SIZE_4B;
  assign m_arburst = BURST_INCR;
  assign mem_wstb  = 4'b1111;

  // While idle the fill address follows the CPU; otherwise it holds the last beat address.
  assign mem_addr  = (state == IDLE) ? cpu_addr : held_addr;

  refill_beat_ctr #(
    .ADDR_W (ADDR_W),
    .WORDS  (WORDS)
  ) u_beat_ctr (
    .clk       (clk),
    .reset     (reset),
    .clear     (launch),
    .inc       (r_hs),
    .base      (base),
    .beat_addr (beat_addr),
    .is_last   (beat_is_last)
  );

  // Refill sequencer with registered AXI handshakes and fill-port strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      base           <= '0;
      held_addr      <= '0;
      end_pending    <= 1'b0;
      mem_data_in    <= '0;
      mem_data_valid <= 1'b0;
      mem_last       <= 1'b0;
      m_arvalid      <= 1'b0;
      m_rready       <= 1'b0;
      err            <= 1'b0;
    end else begin
      // Fill strobe is a single-cycle pulse unless a beat is accepted below.
      mem_data_valid <= 1'b0;
      mem_last       <= 1'b0;
      err            <= err | beat_err;

      case (state)
        IDLE: begin
          held_addr   <= cpu_addr;
          mem_data_in <= '0;
          if (miss) begin
            base      <= line_base;
            m_arvalid <= 1'b1;
            state     <= ADDR;
          end
        end

        ADDR: begin
          if (ar_hs) begin
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
            state     <= DATA;
          end
        end

        DATA: begin
          if (r_hs) begin
            // Forward the beat next cycle and drop ready so strobes never abut.
            mem_data_valid <= 1'b1;
            mem_data_in    <= m_rdata;
            held_addr      <= beat_addr;
            mem_last       <= beat_is_last;
            m_rready       <= 1'b0;
            end_pending    <= beat_is_last || m_rlast;
          end else if (mem_data_valid) begin
            // Strobe cycle just issued: either finish the line or reopen R.
            if (end_pending) begin
              end_pending <= 1'b0;
              state       <= DONE;
            end else begin
              m_rready <= 1'b1;
            end
          end
        end

        DONE: begin
          // Wait for the cache to drop the miss so a stale request is not relaunched.
          if (!miss) begin
            mem_data_in <= '0;
            state       <= IDLE;
          end
        end

        default: begin
          m_arvalid   <= 1'b0;
          m_rready    <= 1'b0;
          end_pending <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl with a fill-port scoreboard.
module tb_cache_refill_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        miss;
  logic [31:0] cpu_addr;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic        mem_data_valid;
  logic        mem_last;
  logic [3:0]  mem_wstb;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast;
  logic        m_rvalid;
  logic        m_rready;
  logic        err;

  int tests = 0;
  int fails = 0;
  int strobe_cnt = 0;
  int last_cnt = 0;
  logic prev_valid = 1'b0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t sb[$];

  always #5 clk = ~clk;

  cache_refill_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .miss           (miss),
    .cpu_addr       (cpu_addr),
    .mem_addr       (mem_addr),
    .mem_data_in    (mem_data_in),
    .mem_data_valid (mem_data_valid),
    .mem_last       (mem_last),
    .mem_wstb       (mem_wstb),
    .m_araddr       (m_araddr),
    .m_arlen        (m_arlen),
    .m_arsize       (m_arsize),
    .m_arburst      (m_arburst),
    .m_arvalid      (m_arvalid),
    .m_arready      (m_arready),
    .m_rdata        (m_rdata),
    .m_rresp        (m_rresp),
    .m_rlast        (m_rlast),
    .m_rvalid       (m_rvalid),
    .m_rready       (m_rready),
    .err            (err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every fill strobe.
  always @(negedge clk) begin
    beat_t e;
    if (!reset && mem_data_valid) begin
      check("no_back_to_back", {63'd0, prev_valid}, 64'd0);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_strobe: addr 0x%0h with empty scoreboard", mem_addr);
      end else begin
        e = sb.pop_front();
        check("strobe_addr", {32'd0, mem_addr}, {32'd0, e.addr});
        check("strobe_data", {32'd0, mem_data_in}, {32'd0, e.data});
        check("strobe_last", {63'd0, mem_last}, {63'd0, e.last});
      end
      strobe_cnt <= strobe_cnt + 1;
      if (mem_last) last_cnt <= last_cnt + 1;
    end
    prev_valid <= reset ? 1'b0 : mem_data_valid;
  end

  // Call at posedge+1 in IDLE: raise the miss for addr.
  task automatic launch(input logic [31:0] addr);
    cpu_addr = addr;
    miss = 1'b1;
  endtask

  // Expect an AR for exp_addr, accept it after 'delay' stall cycles; ends at posedge+1.
  task automatic ar_phase(input logic [31:0] exp_addr, input int delay);
    int held = 0;
    int t = 0;
    @(negedge clk);
    while (!m_arvalid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("ar_valid_seen", {63'd0, m_arvalid}, 64'd1);
    check("ar_addr", {32'd0, m_araddr}, {32'd0, exp_addr});
    check("ar_len", {56'd0, m_arlen}, 64'd31);
    check("ar_size", {61'd0, m_arsize}, 64'd2);
    check("ar_burst", {62'd0, m_arburst}, 64'd1);
    for (int i = 0; i < delay; i++) begin
      if (m_arvalid) held++;
      @(negedge clk);
      check("ar_addr_stable", {32'd0, m_araddr}, {32'd0, exp_addr});
    end
    if (m_arvalid) held++;
    m_arready = 1'b1;
    @(posedge clk);
    #1;
    m_arready = 1'b0;
    check("ar_held_cycles", 64'(held), 64'(delay + 1));
    check("ar_dropped", {63'd0, m_arvalid}, 64'd0);
  endtask

  // Present one R beat (call at posedge+1); push its expected fill when accepted.
  task automatic r_beat(input logic [31:0] d, input logic [1:0] resp, input logic last,
                        input logic [31:0] exp_addr, input logic exp_last);
    int t = 0;
    bit done = 1'b0;
    m_rvalid = 1'b1;
    m_rdata  = d;
    m_rresp  = resp;
    m_rlast  = last;
    while (!done && t < 40) begin
      @(negedge clk);
      if (m_rready) begin
        sb.push_back('{addr: exp_addr, data: d, last: exp_last});
        @(posedge clk);
        #1;
        done = 1'b1;
        check("fill_latency", {63'd0, mem_data_valid}, 64'd1);
      end else begin
        @(posedge clk);
        #1;
        t++;
      end
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    m_rresp  = 2'b00;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL r_timeout: rready never seen for beat at 0x%0h", exp_addr);
    end
  endtask

  // Let the last strobe reach the monitor, then release the miss and settle in IDLE.
  task automatic close_miss();
    repeat (2) @(posedge clk);
    #1;
    miss = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int s0;
    int l0;
    reset = 1'b1;
    miss = 1'b0;
    cpu_addr = 32'h1234_5678;
    m_arready = 1'b0;
    m_rdata = 32'd0;
    m_rresp = 2'b00;
    m_rlast = 1'b0;
    m_rvalid = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {63'd0, mem_data_valid}, 64'd0);
    check("rst_last", {63'd0, mem_last}, 64'd0);
    check("rst_arvalid", {63'd0, m_arvalid}, 64'd0);
    check("rst_rready", {63'd0, m_rready}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    check("rst_data", {32'd0, mem_data_in}, 64'd0);
    check("rst_wstb", {60'd0, mem_wstb}, 64'hF);
    check("idle_passthru", {32'd0, mem_addr}, 64'h1234_5678);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 1: miss at 0x0001_2344, arready after 3 stall cycles.
    launch(32'h0001_2344);
    ar_phase(32'h0001_2300, 3);

    // 2: 32 beats, alternating data, rvalid kept high.
    s0 = strobe_cnt;
    l0 = last_cnt;
    for (int i = 0; i < 32; i++) begin
      r_beat((i % 2 == 0) ? 32'hAAAA_AAAA : 32'h5555_5555, 2'b00, (i == 31),
             32'h0001_2300 + 32'(4 * i), (i == 31));
    end

    // 3: miss held two more cycles -> no relaunch; IDLE one cycle after miss falls.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("done_no_ar", {63'd0, m_arvalid}, 64'd0);
      check("done_no_rready", {63'd0, m_rready}, 64'd0);
      @(posedge clk);
      #1;
    end
    check("burst_strobes", 64'(strobe_cnt - s0), 64'd32);
    check("burst_lasts", 64'(last_cnt - l0), 64'd1);
    check("err_clean", {63'd0, err}, 64'd0);
    cpu_addr = 32'h0000_5008;
    miss = 1'b0;
    @(negedge clk);
    check("done_addr_hold", {32'd0, mem_addr}, 64'h0001_237C);
    @(posedge clk);
    #1;
    check("idle_after_miss", {32'd0, mem_addr}, 64'h0000_5008);
    check("idle_data_zero", {32'd0, mem_data_in}, 64'd0);
    cpu_addr = 32'h0000_ABCC;
    #1;
    check("idle_tracks", {32'd0, mem_addr}, 64'h0000_ABCC);
    @(posedge clk);
    #1;

    // 4: SLVERR on the fifth beat; burst still completes.
    launch(32'h0000_8044);
    ar_phase(32'h0000_8000, 0);
    s0 = strobe_cnt;
    l0 = last_cnt;
    for (int i = 0; i < 32; i++) begin
      r_beat(32'h1000_0000 + 32'(i), (i == 4) ? 2'b10 : 2'b00, (i == 31),
             32'h0000_8000 + 32'(4 * i), (i == 31));
      if (i == 3) check("err_before_bad", {63'd0, err}, 64'd0);
      if (i == 4) check("err_on_bad", {63'd0, err}, 64'd1);
    end
    close_miss();
    check("resp_strobes", 64'(strobe_cnt - s0), 64'd32);
    check("resp_lasts", 64'(last_cnt - l0), 64'd1);
    check("err_sticky", {63'd0, err}, 64'd1);

    // 5: rlast early on beat 10.
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("err_cleared", {63'd0, err}, 64'd0);
    launch(32'h0002_0F80);
    ar_phase(32'h0002_0F80, 1);
    s0 = strobe_cnt;
    l0 = last_cnt;
    for (int i = 0; i < 10; i++) begin
      r_beat(32'hC0DE_0000 + 32'(i), 2'b00, (i == 9), 32'h0002_0F80 + 32'(4 * i), 1'b0);
    end
    cpu_addr = 32'h0000_0100;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("early_no_rready", {63'd0, m_rready}, 64'd0);
      check("early_no_ar", {63'd0, m_arvalid}, 64'd0);
      @(posedge clk);
      #1;
    end
    check("early_done_hold", {32'd0, mem_addr}, 64'h0002_0FA4);
    check("early_strobes", 64'(strobe_cnt - s0), 64'd10);
    check("early_no_last", 64'(last_cnt - l0), 64'd0);
    check("early_err", {63'd0, err}, 64'd1);
    close_miss();

    // 6: reset during beat 15, then a fresh burst from beat 0.
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    launch(32'h0003_0104);
    ar_phase(32'h0003_0100, 0);
    for (int i = 0; i < 14; i++) begin
      r_beat(32'h7700_0000 + 32'(i), 2'b00, 1'b0, 32'h0003_0100 + 32'(4 * i), 1'b0);
    end
    m_rvalid = 1'b1;
    m_rdata = 32'h7700_000E;
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("arst_valid", {63'd0, mem_data_valid}, 64'd0);
    check("arst_last", {63'd0, mem_last}, 64'd0);
    check("arst_arvalid", {63'd0, m_arvalid}, 64'd0);
    check("arst_rready", {63'd0, m_rready}, 64'd0);
    check("arst_data", {32'd0, mem_data_in}, 64'd0);
    check("arst_araddr", {32'd0, m_araddr}, 64'd0);
    check("arst_sb_empty", 64'(sb.size()), 64'd0);
    m_rvalid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("arst_idle_passthru", {32'd0, mem_addr}, 64'h0003_0104);
    s0 = strobe_cnt;
    l0 = last_cnt;
    ar_phase(32'h0003_0100, 2);
    for (int i = 0; i < 32; i++) begin
      r_beat(~32'(i), 2'b00, (i == 31), 32'h0003_0100 + 32'(4 * i), (i == 31));
    end
    close_miss();
    check("restart_strobes", 64'(strobe_cnt - s0), 64'd32);
    check("restart_lasts", 64'(last_cnt - l0), 64'd1);
    check("restart_err", {63'd0, err}, 64'd0);
    check("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
Sequences cache line refills on a miss. Turns the cache's miss request into a single AXI4 INCR read burst and replays the returned beats onto the cache's word-fill interface (mem_addr / mem_data_in / mem_data_valid / mem_last). Sits between the cache and the AXI interconnect and is the only master of the cache fill port.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data/beat width; fixed at 32 for this cache
LINE_BYTES, 128, cache line size; WORDS = LINE_BYTES/4 = 32 beats; CNT_W = $clog2(WORDS)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
miss  in  1  cache miss/refill request, held high by cache until refill completes
cpu_addr  in  ADDR_W  address of the missing access
mem_addr  out  ADDR_W  word address of current fill beat
mem_data_in  out  DATA_W  fill data to cache
mem_data_valid  out  1  one-cycle fill strobe
mem_last  out  1  marks final word of line, coincident with mem_data_valid
mem_wstb  out  4  fill byte strobe, constant 4'b1111
m_araddr  out  ADDR_W  AXI read address
m_arlen  out  8  burst length - 1
m_arsize  out  3  beat size
m_arburst  out  2  burst type
m_arvalid  out  1  AR valid
m_arready  in  1  AR ready
m_rdata  in  DATA_W  R data
m_rresp  in  2  R response
m_rlast  in  1  R last
m_rvalid  in  1  R valid
m_rready  out  1  R ready
err  out  1  sticky refill error

Behaviour:
- Reset (async, active-high): state IDLE; mem_data_valid, mem_last, m_arvalid, m_rready, err = 0; mem_data_in = 0; beat counter = 0. mem_wstb = 4'b1111 always.
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE: mem_addr = cpu_addr (combinational pass-through); mem_data_in = 0; valid/last = 0. On miss: latch base = {cpu_addr[ADDR_W-1:7], 7'b0}, clear counter, go to ADDR.
- ADDR: m_arvalid = 1; m_araddr = base; m_arlen = WORDS-1 (31); m_arsize = 3'b010; m_arburst = 2'b01 (INCR). AR fields are stable while arvalid is high. On arvalid && arready, go to DATA the next cycle.
- DATA: m_rready = 1 only when mem_data_valid is currently low. This limits the cache fill rate to at most one beat per 2 cycles, because mem_data_valid must never be high two cycles in a row.
- On an R handshake, the next cycle has: mem_data_valid = 1; mem_data_in = m_rdata; mem_addr = base + 4*counter (registered); mem_last = (counter == WORDS-1). The counter then increments.
- Latency: R handshake to mem_data_valid is exactly 1 cycle.
- mem_addr holds its last value between strobes.
- After the last beat's strobe, go to DONE.
- DONE: mem_addr holds; valid/last = 0. Wait for miss == 0, then go to IDLE. This prevents relaunching on a stale miss.
- Errors, all setting sticky err, which clears only on reset:
  - m_rresp != 2'b00 on any beat: the beat is still forwarded and the burst completes.
  - m_rlast == 1 with counter != WORDS-1: the beat is forwarded and the controller ends early (DONE) without asserting mem_last.
  - m_rlast == 0 on beat WORDS-1: mem_last is still asserted and the controller proceeds to DONE.
- miss going low during ADDR or DATA: ignored; the burst always completes (AXI transactions cannot be cancelled).
- Reset mid-burst: everything returns to reset values immediately; no outstanding state is retained.
- counter wraps never occur; it is bounded to WORDS-1.

Decomposition:
- Shared package cache_pkg holds:
  - state enum
  - LINE_BYTES, WORDS, OFFSET_W (7)
  - AXI constants: BURST_INCR = 2'b01, SIZE_4B = 3'b010, RESP_OKAY = 2'b00
- Optional sub-module refill_beat_ctr: counter plus address generator (base + 4*cnt, last flag).
- The FSM stays in the top.

Test Plan:
1. miss=1 with cpu_addr=0x0001_2344, arready delayed 3 cycles → araddr=0x0001_2300, arlen=31, arsize=2, arburst=1, arvalid held 4 cycles.
2. Slave returns 32 beats with rvalid constantly high, data alternating 0xAAAAAAAA/0x55555555 → 32 mem_data_valid pulses, never back-to-back; mem_addr = 0x0001_2300..0x0001_237C in steps of 4; mem_last only with the 32nd.
3. After the last beat, miss held high 2 more cycles → no new AR; IDLE is entered the cycle after miss falls; mem_addr then tracks cpu_addr.
4. rresp=2'b10 on beat 5 → err=1 and stays 1; all 32 beats still delivered; mem_last still asserted.
5. rlast early on beat 10 → err=1, 10 strobes delivered, no mem_last, FSM reaches DONE.
6. reset asserted during beat 15 → all outputs zero asynchronously; after release, a new miss restarts a burst from beat 0.
